// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port block-RAM arbiter.
// Optional build macro used by this slice: MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 20;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the block RAM.
// slave = arbiter view; master = requesters plus RAM (the arbiter's environment).
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    // Handshake: a port holds req (and rw/addr/wdata) stable until it samples
    // ready=1, then drops req on that same edge; ready is a one-cycle pulse and
    // rdata is valid while it is high. Toward the RAM, mem_req holds with stable
    // mem_rw/mem_addr/mem_wdata until one mem_ready pulse carries mem_rdata.
    logic              p0_req;
    logic              p0_rw;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ready;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_rw;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ready;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              err;

    modport slave (
        input  p0_req, p0_rw, p0_addr, p0_wdata,
        input  p1_req, p1_rw, p1_addr, p1_wdata,
        input  mem_rdata, mem_ready,
        output p0_ready, p0_rdata, p1_ready, p1_rdata,
        output mem_req, mem_rw, mem_addr, mem_wdata, err
    );

    modport master (
        output p0_req, p0_rw, p0_addr, p0_wdata,
        output p1_req, p1_rw, p1_addr, p1_wdata,
        output mem_rdata, mem_ready,
        input  p0_ready, p0_rdata, p1_ready, p1_rdata,
        input  mem_req, mem_rw, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant selection; purely combinational.
// The last_grant register is owned by the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic any_req
);

    always_comb begin
        any_req = req0 | req1;
        grant   = PORT_I;
        // On a tie the port that was not served last time wins.
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block RAM between the I-side and D-side ports.
// Define MEM_ARB_TIMEOUT_EN to abort RAM accesses that exceed TIMEOUT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output arb_state_t   state_dbg
);

    arb_state_t        state, state_nxt;
    logic              grant_q, grant_nxt;
    logic              last_q, last_nxt;
    logic              mem_req_q, mem_req_nxt;
    logic              mem_rw_q, mem_rw_nxt;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_nxt;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_nxt;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_nxt;
    logic              p0_ready_q, p0_ready_nxt;
    logic              p1_ready_q, p1_ready_nxt;
    logic              complete;
    logic [DATA_W-1:0] complete_data;
    logic              arb_grant;
    logic              arb_any;

    rr_arb2 u_rr_arb2 (
        .req0       (bus.p0_req),
        .req1       (bus.p1_req),
        .last_grant (last_q),
        .grant      (arb_grant),
        .any_req    (arb_any)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             err_q, err_nxt;

    // Zero whenever not BUSY, so each BUSY stint starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == BUSY) && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_nxt;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign bus.err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_q     <= PORT_I;
            last_q      <= PORT_D;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_ready_q  <= 1'b0;
            p1_ready_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant_q     <= grant_nxt;
            last_q      <= last_nxt;
            mem_req_q   <= mem_req_nxt;
            mem_rw_q    <= mem_rw_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            p0_rdata_q  <= p0_rdata_nxt;
            p1_rdata_q  <= p1_rdata_nxt;
            p0_ready_q  <= p0_ready_nxt;
            p1_ready_q  <= p1_ready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_q;
        last_nxt      = last_q;
        mem_req_nxt   = mem_req_q;
        mem_rw_nxt    = mem_rw_q;
        mem_addr_nxt  = mem_addr_q;
        mem_wdata_nxt = mem_wdata_q;
        p0_rdata_nxt  = p0_rdata_q;
        p1_rdata_nxt  = p1_rdata_q;
        p0_ready_nxt  = 1'b0;
        p1_ready_nxt  = 1'b0;
        complete      = 1'b0;
        complete_data = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        err_nxt       = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt     = BUSY;
                    grant_nxt     = arb_grant;
                    last_nxt      = arb_grant;
                    mem_req_nxt   = 1'b1;
                    mem_rw_nxt    = (arb_grant == PORT_D) ? bus.p1_rw    : bus.p0_rw;
                    mem_addr_nxt  = (arb_grant == PORT_D) ? bus.p1_addr  : bus.p0_addr;
                    mem_wdata_nxt = (arb_grant == PORT_D) ? bus.p1_wdata : bus.p0_wdata;
                end
            end
            BUSY: begin
                // A RAM answer in the expiry cycle still counts as a normal completion.
                if (bus.mem_ready) begin
                    complete      = 1'b1;
                    complete_data = bus.mem_rdata;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    complete = 1'b1;
                    err_nxt  = 1'b1;
                end
`endif
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (complete) begin
            state_nxt   = RESP;
            mem_req_nxt = 1'b0;
            if (grant_q == PORT_D) begin
                p1_rdata_nxt = complete_data;
                p1_ready_nxt = 1'b1;
            end else begin
                p0_rdata_nxt = complete_data;
                p0_ready_nxt = 1'b1;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.p0_ready  = p0_ready_q;
    assign bus.p1_ready  = p1_ready_q;
    assign state_dbg     = state;

endmodule
